// File: rtl/cpu_tlb_pkg.sv
// Shared TLB types: entry layout, CP0 op encoding, exception flags and the
// per-port translation helper used by both lookup ports.
package cpu_tlb_pkg;

    localparam int TLB_NUM = 16;
    localparam int IDXW    = $clog2(TLB_NUM);

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } TLBEntryType;

    typedef enum logic [2:0] {
        TLB_NOP   = 3'd0,
        TLB_TLBP  = 3'd1,
        TLB_TLBR  = 3'd2,
        TLB_TLBWI = 3'd3,
        TLB_TLBWR = 3'd4
    } TLBOpType;

    typedef struct packed {
        logic refill;
        logic invalid;
        logic modified;
    } TLBExcType;

    typedef struct packed {
        logic [31:0] paddr;
        TLBExcType   exc;
    } TLBXlatType;

    // kseg0/kseg1 bypass the TLB; otherwise pick the even/odd half by vaddr[12].
    function automatic TLBXlatType tlb_translate(input logic [31:0] vaddr, input logic hit,
                                                 input TLBEntryType e, input logic wr);
        TLBXlatType r;
        logic [19:0] pfn;
        logic v;
        logic d;
        r   = '0;
        pfn = vaddr[12] ? e.pfn1 : e.pfn0;
        v   = vaddr[12] ? e.v1 : e.v0;
        d   = vaddr[12] ? e.d1 : e.d0;
        if (vaddr[31:30] == 2'b10) begin
            r.paddr = {3'b000, vaddr[28:0]};
        end else if (!hit) begin
            r.exc.refill = 1'b1;
        end else if (!v) begin
            r.exc.invalid = 1'b1;
        end else if (wr && !d) begin
            r.exc.modified = 1'b1;
        end else begin
            r.paddr = {pfn, vaddr[11:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/tlb_match.sv
// Combinational associative compare of {vpn2,asid} against every entry;
// the lowest matching index wins so multiple hits stay deterministic.
module tlb_match
    import cpu_tlb_pkg::*;
(
    input  TLBEntryType [TLB_NUM-1:0] i_entries,
    input  logic [18:0]               i_vpn2,
    input  logic [7:0]                i_asid,
    output logic                      o_hit,
    output logic [IDXW-1:0]           o_idx
);

    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = TLB_NUM - 1; i >= 0; i--) begin
            if (i_entries[i].vpn2 == i_vpn2 && (i_entries[i].g || i_entries[i].asid == i_asid)) begin
                o_hit = 1'b1;
                o_idx = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/tlb_mmu.sv
// Joint TLB: entry array, random replacement counter, registered fetch/data
// translation and execution of TLBP/TLBR/TLBWI/TLBWR issued from WB.
module tlb_mmu
    import cpu_tlb_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_en,
    input  logic [31:0]       i_vaddr,
    output logic [31:0]       i_paddr,
    output TLBExcType         i_exc,
    input  logic              d_en,
    input  logic [31:0]       d_vaddr,
    input  logic              d_wr,
    output logic [31:0]       d_paddr,
    output TLBExcType         d_exc,
    input  logic [7:0]        cur_asid,
    input  logic [2:0]        tlb_op,
    input  TLBEntryType       cp0_entry,
    input  logic [IDXW-1:0]   cp0_index,
    output TLBEntryType       mmu_entry,
    output logic [IDXW-1:0]   mmu_index,
    output logic              probe_miss,
    output logic              op_done
);

    TLBEntryType [TLB_NUM-1:0] r_entries;
    logic [IDXW-1:0]           r_random;
    TLBXlatType                r_i_res;
    TLBXlatType                r_d_res;
    TLBEntryType               r_mmu_entry;
    logic [IDXW-1:0]           r_mmu_index;
    logic                      r_probe_miss;
    logic                      r_op_done;

    logic            w_i_hit, w_d_hit, w_p_hit;
    logic [IDXW-1:0] w_i_idx, w_d_idx, w_p_idx;
    TLBOpType        w_op;
    logic            w_op_valid;

    assign w_op       = TLBOpType'(tlb_op);
    assign w_op_valid = (tlb_op != 3'd0) && (tlb_op <= 3'd4);

    tlb_match u_match_i (.i_entries(r_entries), .i_vpn2(i_vaddr[31:13]), .i_asid(cur_asid),
                         .o_hit(w_i_hit), .o_idx(w_i_idx));
    tlb_match u_match_d (.i_entries(r_entries), .i_vpn2(d_vaddr[31:13]), .i_asid(cur_asid),
                         .o_hit(w_d_hit), .o_idx(w_d_idx));
    tlb_match u_match_p (.i_entries(r_entries), .i_vpn2(cp0_entry.vpn2), .i_asid(cp0_entry.asid),
                         .o_hit(w_p_hit), .o_idx(w_p_idx));

    // Lookups and writes share one edge: lookups read the pre-write array.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_entries    <= '0;
            r_random     <= IDXW'(TLB_NUM - 1);
            r_i_res      <= '0;
            r_d_res      <= '0;
            r_mmu_entry  <= '0;
            r_mmu_index  <= '0;
            r_probe_miss <= 1'b0;
            r_op_done    <= 1'b0;
        end else begin
            r_random  <= r_random - IDXW'(1);
            r_op_done <= w_op_valid;
            if (i_en) r_i_res <= tlb_translate(i_vaddr, w_i_hit, r_entries[w_i_idx], 1'b0);
            if (d_en) r_d_res <= tlb_translate(d_vaddr, w_d_hit, r_entries[w_d_idx], d_wr);
            case (w_op)
                TLB_TLBP: begin
                    r_mmu_index  <= w_p_hit ? w_p_idx : '0;
                    r_probe_miss <= !w_p_hit;
                end
                TLB_TLBR:  r_mmu_entry          <= r_entries[cp0_index];
                TLB_TLBWI: r_entries[cp0_index] <= cp0_entry;
                TLB_TLBWR: r_entries[r_random]  <= cp0_entry;
                default: ;
            endcase
        end
    end

    assign i_paddr    = r_i_res.paddr;
    assign i_exc      = r_i_res.exc;
    assign d_paddr    = r_d_res.paddr;
    assign d_exc      = r_d_res.exc;
    assign mmu_entry  = r_mmu_entry;
    assign mmu_index  = r_mmu_index;
    assign probe_miss = r_probe_miss;
    assign op_done    = r_op_done;

endmodule
